// File: rtl/ama_riscv_mem_arbiter_if.sv
// Request/response channel shared by the cache refill paths and main memory.
// master drives requests and consumes responses; slave accepts and answers.
interface ama_riscv_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [LINE_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [LINE_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ama_riscv_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I$ refill
// path and the D$ refill/writeback path, one transaction in flight.
//
// state    | meaning
// IDLE     | waiting for a request, ready driven to the arbitration winner
// ISSUE    | memory request presented, held until mem accepts
// WAIT_RSP | read issued, waiting for memory read data
// RESP     | one-cycle response pulse to the owning requester
module ama_riscv_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  ama_riscv_mem_arbiter_if.slave  ic,
  ama_riscv_mem_arbiter_if.slave  dc,
  ama_riscv_mem_arbiter_if.master mem,
  output logic                   busy_o,
  output logic                   last_grant_o,
  output logic                   proto_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

  state_t            state_q;
  logic              owner_q;        // 0 = I$, 1 = D$
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic              mem_valid_q;
  logic              last_grant_q;
  logic              proto_err_q;
  logic              ic_rsp_valid_q;
  logic              dc_rsp_valid_q;
  logic [LINE_W-1:0] ic_rsp_data_q;
  logic [LINE_W-1:0] dc_rsp_data_q;
  logic              ic_pick;
  logic              dc_pick;

  // Arbitration: a lone requester wins; a tie goes to whoever was not granted last.
  always_comb begin
    ic_pick = ic.req_valid & (~dc.req_valid | last_grant_q);
    dc_pick = dc.req_valid & (~ic.req_valid | ~last_grant_q);
  end

  // Ready is only offered in IDLE and is held low while reset is asserted.
  assign ic.req_ready   = (state_q == IDLE) & ~rst & ic_pick;
  assign dc.req_ready   = (state_q == IDLE) & ~rst & dc_pick;

  assign mem.req_valid  = mem_valid_q;
  assign mem.req_addr   = addr_q;
  assign mem.req_we     = we_q;
  assign mem.req_wdata  = wdata_q;
  assign ic.rsp_valid   = ic_rsp_valid_q;
  assign ic.rsp_data    = ic_rsp_data_q;
  assign dc.rsp_valid   = dc_rsp_valid_q;
  assign dc.rsp_data    = dc_rsp_data_q;
  assign busy_o         = (state_q != IDLE);
  assign last_grant_o   = last_grant_q;
  assign proto_err_o    = proto_err_q;

  // Transaction FSM with registered memory request and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      mem_valid_q    <= 1'b0;
      last_grant_q   <= 1'b0;
      proto_err_q    <= 1'b0;
      ic_rsp_valid_q <= 1'b0;
      dc_rsp_valid_q <= 1'b0;
      ic_rsp_data_q  <= '0;
      dc_rsp_data_q  <= '0;
    end else begin
      ic_rsp_valid_q <= 1'b0;
      dc_rsp_valid_q <= 1'b0;
      // Read data arriving when nothing is waiting for it is dropped and flagged.
      if (mem.rsp_valid && (state_q != WAIT_RSP)) proto_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (ic_pick || dc_pick) begin
            owner_q      <= dc_pick;
            addr_q       <= dc_pick ? dc.req_addr : ic.req_addr;
            we_q         <= dc_pick & dc.req_we;
            wdata_q      <= dc_pick ? dc.req_wdata : '0;
            last_grant_q <= dc_pick;
            mem_valid_q  <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem.req_ready) begin
            mem_valid_q <= 1'b0;
            if (we_q) begin
              // Only the D$ can write, so the completion always goes there.
              dc_rsp_valid_q <= 1'b1;
              dc_rsp_data_q  <= '0;
              state_q        <= RESP;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (mem.rsp_valid) begin
            if (owner_q) begin
              dc_rsp_valid_q <= 1'b1;
              dc_rsp_data_q  <= mem.rsp_data;
            end else begin
              ic_rsp_valid_q <= 1'b1;
              ic_rsp_data_q  <= mem.rsp_data;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
